// File: rtl/clock_rate_sequencer.sv
// Programmable clock generator: produces io_clk_o from the system clock with a
// runtime half-period, running a fixed number of periods or free-running until stopped.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom;
endpackage

module clock_rate_sequencer #(
  parameter int HALF_W = 16
) (
  input  common_p::clk_dom    sys_dom_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [HALF_W-1:0]   half_rate_i,
  input  logic [HALF_W-1:0]   period_count_i,
  output logic                io_clk_o,
  output logic                half_rate_elapsed_o,
  output logic                quarter_rate_elapsed_o,
  output logic                clock_active_o,
  output logic                done_o,
  output logic [HALF_W-1:0]   periods_done_o,
  output logic                dbg_state_o
);

  // Handshake: start_i/stop_i are single-cycle requests sampled on the rising
  // edge; start_i is taken only in IDLE, stop_i only in RUN (and is deferred to
  // the end of the current io_clk period). There is no back-pressure.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic                clk;
  logic                rst_n;
  state_t              state;
  logic [HALF_W-1:0]   half_q;
  logic [HALF_W-1:0]   count_q;
  logic [HALF_W-1:0]   cnt;
  logic                stop_pending;
  logic                half_last;
  logic                quarter_hit;
  logic                count_hit;
  logic [HALF_W-1:0]   periods_next;
  logic [HALF_W-1:0]   half_min;
  logic [HALF_W:0]     periods_inc;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  // A half-period below two system clocks would collapse the quarter point.
  assign half_min     = (half_rate_i < HALF_W'(2)) ? HALF_W'(2) : half_rate_i;
  assign half_last    = (state == RUN) && (cnt == half_q - HALF_W'(1));
  assign quarter_hit  = (state == RUN) && (cnt == (half_q >> 1) - HALF_W'(1));
  assign periods_next = (&periods_done_o) ? periods_done_o : periods_done_o + HALF_W'(1);
  assign periods_inc  = {1'b0, periods_done_o} + (HALF_W+1)'(1);
  assign count_hit    = (count_q != '0) && (periods_inc == {1'b0, count_q});

  assign half_rate_elapsed_o    = half_last;
  assign quarter_rate_elapsed_o = quarter_hit;
  assign dbg_state_o            = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      half_q         <= '0;
      count_q        <= '0;
      cnt            <= '0;
      stop_pending   <= 1'b0;
      io_clk_o       <= 1'b0;
      clock_active_o <= 1'b0;
      done_o         <= 1'b0;
      periods_done_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            half_q         <= half_min;
            count_q        <= period_count_i;
            cnt            <= '0;
            periods_done_o <= '0;
            stop_pending   <= 1'b0;
            io_clk_o       <= 1'b0;
            clock_active_o <= 1'b1;
            state          <= RUN;
          end
        end
        RUN: begin
          if (stop_i) stop_pending <= 1'b1;
          if (half_last) begin
            cnt      <= '0;
            io_clk_o <= ~io_clk_o;
            // Falling edge closes a full period; only here may the run end.
            if (io_clk_o) begin
              periods_done_o <= periods_next;
              if (stop_pending || count_hit) begin
                state          <= IDLE;
                io_clk_o       <= 1'b0;
                clock_active_o <= 1'b0;
                stop_pending   <= 1'b0;
                done_o         <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + HALF_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_rate_sequencer.sv
// Bench for clock_rate_sequencer: each run is predicted from period arithmetic
// (half-period h, number of periods P) and compared cycle by cycle.
module tb_clock_rate_sequencer;
  localparam int HALF_W = 4;
  localparam int SAT = (1 << HALF_W) - 1;

  logic clk;
  logic rst_n;
  logic start_i, stop_i;
  logic [HALF_W-1:0] half_rate_i, period_count_i;
  logic io_clk_o, half_rate_elapsed_o, quarter_rate_elapsed_o;
  logic clock_active_o, done_o, dbg_state_o;
  logic [HALF_W-1:0] periods_done_o;
  common_p::clk_dom sys_dom;

  int n_total = 0;
  int n_bad = 0;

  assign sys_dom.clk   = clk;
  assign sys_dom.rst_n = rst_n;

  clock_rate_sequencer #(.HALF_W(HALF_W)) dut (
    .sys_dom_i              (sys_dom),
    .start_i                (start_i),
    .stop_i                 (stop_i),
    .half_rate_i            (half_rate_i),
    .period_count_i         (period_count_i),
    .io_clk_o               (io_clk_o),
    .half_rate_elapsed_o    (half_rate_elapsed_o),
    .quarter_rate_elapsed_o (quarter_rate_elapsed_o),
    .clock_active_o         (clock_active_o),
    .done_o                 (done_o),
    .periods_done_o         (periods_done_o),
    .dbg_state_o            (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a run now (mid-cycle) and check every cycle until one past done.
  task automatic run_check(input int hr, input int pc, input int stop_at,
                           input bit stop_with_start, input bit noise, input string name);
    int h, p_stop, p, total;
    logic e_io, e_half, e_quarter, e_active, e_done;
    logic [HALF_W-1:0] e_periods;
    h = (hr < 2) ? 2 : hr;
    p_stop = (stop_at >= 0) ? ((stop_at + 1) / (2 * h) + 1) : 0;
    if (pc == 0) p = p_stop;
    else if (p_stop == 0) p = pc;
    else p = (pc < p_stop) ? pc : p_stop;
    total = 2 * h * p;
    start_i = 1'b1;
    stop_i = stop_with_start;
    half_rate_i = HALF_W'(hr);
    period_count_i = HALF_W'(pc);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    stop_i = 1'b0;
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      if (k < total) begin
        e_active  = 1'b1;
        e_io      = ((k / h) % 2) == 1;
        e_half    = (k % h) == h - 1;
        e_quarter = (k % h) == h / 2 - 1;
        e_periods = HALF_W'(((k / (2 * h)) > SAT) ? SAT : (k / (2 * h)));
        e_done    = 1'b0;
      end else begin
        e_active  = 1'b0;
        e_io      = 1'b0;
        e_half    = 1'b0;
        e_quarter = 1'b0;
        e_periods = HALF_W'((p > SAT) ? SAT : p);
        e_done    = (k == total);
      end
      if (io_clk_o !== e_io) begin n_bad++; $display("FAIL %s io_clk k=%0d got=%b exp=%b", name, k, io_clk_o, e_io); end
      if (half_rate_elapsed_o !== e_half) begin n_bad++; $display("FAIL %s half_elapsed k=%0d got=%b exp=%b", name, k, half_rate_elapsed_o, e_half); end
      if (quarter_rate_elapsed_o !== e_quarter) begin n_bad++; $display("FAIL %s quarter_elapsed k=%0d got=%b exp=%b", name, k, quarter_rate_elapsed_o, e_quarter); end
      if (clock_active_o !== e_active) begin n_bad++; $display("FAIL %s clock_active k=%0d got=%b exp=%b", name, k, clock_active_o, e_active); end
      if (dbg_state_o !== e_active) begin n_bad++; $display("FAIL %s dbg_state k=%0d got=%b exp=%b", name, k, dbg_state_o, e_active); end
      if (done_o !== e_done) begin n_bad++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, done_o, e_done); end
      if (periods_done_o !== e_periods) begin n_bad++; $display("FAIL %s periods_done k=%0d got=%0d exp=%0d", name, k, periods_done_o, e_periods); end
      n_total += 7;
      if (k < total) begin
        stop_i = (k == stop_at);
        if (noise) begin
          start_i = 1'($urandom_range(0, 1));
          half_rate_i = HALF_W'($urandom_range(0, SAT));
          period_count_i = HALF_W'($urandom_range(0, SAT));
        end
      end else begin
        start_i = 1'b0;
        stop_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    start_i = 1'b0;
    stop_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    if (io_clk_o !== 1'b0) begin n_bad++; $display("FAIL %s io_clk got=%b exp=0", name, io_clk_o); end
    if (half_rate_elapsed_o !== 1'b0) begin n_bad++; $display("FAIL %s half_elapsed got=%b exp=0", name, half_rate_elapsed_o); end
    if (quarter_rate_elapsed_o !== 1'b0) begin n_bad++; $display("FAIL %s quarter_elapsed got=%b exp=0", name, quarter_rate_elapsed_o); end
    if (clock_active_o !== 1'b0) begin n_bad++; $display("FAIL %s clock_active got=%b exp=0", name, clock_active_o); end
    if (dbg_state_o !== 1'b0) begin n_bad++; $display("FAIL %s dbg_state got=%b exp=0", name, dbg_state_o); end
    if (done_o !== 1'b0) begin n_bad++; $display("FAIL %s done got=%b exp=0", name, done_o); end
    if (periods_done_o !== '0) begin n_bad++; $display("FAIL %s periods_done got=%0d exp=0", name, periods_done_o); end
    n_total += 7;
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_check(4, 2, -1, 1'b0, 1'b0, "basic_h4_p2");
  endtask

  task automatic test_min_half();
    run_check(0, 2, -1, 1'b0, 1'b0, "min_half_0");
    run_check(1, 1, -1, 1'b0, 1'b0, "min_half_1");
  endtask

  task automatic test_free_run_stop();
    run_check(3, 0, 28, 1'b0, 1'b0, "free_run_stop");
  endtask

  task automatic test_count_and_stop();
    run_check(5, 1, 7, 1'b0, 1'b0, "count_and_stop");
  endtask

  task automatic test_ignore_start();
    half_rate_i = HALF_W'(10);
    run_check(4, 3, -1, 1'b0, 1'b1, "ignore_start_noise");
  endtask

  task automatic test_start_with_stop();
    run_check(2, 2, -1, 1'b1, 1'b0, "start_with_stop");
  endtask

  task automatic test_saturation();
    run_check(2, 0, 85, 1'b0, 1'b0, "saturation");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int hr, pc, h, st;
      hr = $urandom_range(0, 6);
      pc = $urandom_range(0, 4);
      h = (hr < 2) ? 2 : hr;
      if (pc == 0) st = $urandom_range(0, 2 * h * 4 - 1);
      else st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2 * h * pc - 1) : -1;
      run_check(hr, pc, st, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_async_reset();
    start_i = 1'b1;
    half_rate_i = HALF_W'(2);
    period_count_i = '0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (11) @(negedge clk);
    if (io_clk_o !== 1'b1) begin n_bad++; $display("FAIL pre_reset io_clk got=%b exp=1", io_clk_o); end
    if (periods_done_o !== HALF_W'(2)) begin n_bad++; $display("FAIL pre_reset periods_done got=%0d exp=2", periods_done_o); end
    n_total += 2;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_check(5, 2, -1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    half_rate_i = '0;
    period_count_i = '0;
    test_reset();
    test_basic();
    test_min_half();
    test_free_run_stop();
    test_count_and_stop();
    test_ignore_start();
    test_start_with_stop();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_rate_sequencer.md
CLOCK_RATE_SEQUENCER -- requirements
Module: clock_rate_sequencer

Interface
REQ-001 SHALL have parameter HALF_W, default 16: width of the half-period divisor and the period counter.
REQ-002 SHALL have port sys_dom_i.clk, input, 1: single system clock; all state on its rising edge.
REQ-003 SHALL have port sys_dom_i.rst_n, input, 1: reset, asynchronous, active-low; carried in common_p::clk_dom sys_dom_i.
REQ-004 SHALL have port start_i, input, 1: single-cycle start request.
REQ-005 SHALL have port stop_i, input, 1: single-cycle graceful-stop request.
REQ-006 SHALL have port half_rate_i, input, HALF_W: sys clocks per io_clk half-period.
REQ-007 SHALL have port period_count_i, input, HALF_W: full io_clk periods to run; 0 = free-run.
REQ-008 SHALL have port io_clk_o, output, 1: generated clock level.
REQ-009 SHALL have port half_rate_elapsed_o, output, 1: pulse on the last sys cycle of each half-period.
REQ-010 SHALL have port quarter_rate_elapsed_o, output, 1: pulse at the mid-point of each half-period.
REQ-011 SHALL have port clock_active_o, output, 1: high while in RUN.
REQ-012 SHALL have port done_o, output, 1: single-cycle completion pulse.
REQ-013 SHALL have port periods_done_o, output, HALF_W: completed full periods since last start.

Function
REQ-014 States SHALL be IDLE and RUN, plus a registered done pulse; reset state IDLE.
REQ-015 In IDLE, start_i=1 SHALL latch half_q = max(half_rate_i, 2) and count_q = period_count_i, clear cnt, periods_done_o and stop_pending, and enter RUN next cycle.
REQ-016 start_i SHALL be ignored outside IDLE; half_rate_i/period_count_i changes during RUN SHALL have no effect.
REQ-017 In RUN, cnt SHALL increment each cycle; at cnt == half_q-1, half_rate_elapsed_o=1 that cycle, cnt<=0, io_clk_o toggles next cycle.
REQ-018 quarter_rate_elapsed_o SHALL be 1 in RUN when cnt == (half_q>>1)-1 (half_q=2: cnt 0; half_q=3: cnt 0; half_q=8: cnt 3).
REQ-019 Both elapsed outputs SHALL be 0 outside RUN.
REQ-020 io_clk_o SHALL be 0 on RUN entry; the first half-period is low, so the first toggle is a rising edge.
REQ-021 A falling transition (half elapsed while io_clk_o=1) SHALL increment periods_done_o, saturating at all-ones.
REQ-022 stop_i in RUN SHALL set stop_pending; stop_i in IDLE SHALL be ignored; start_i and stop_i together in IDLE: start taken, stop ignored.
REQ-023 On a falling transition where stop_pending=1, or count_q!=0 and periods_done_o+1 == count_q, the block SHALL enter IDLE with io_clk_o=0 and pulse done_o once the next cycle.
REQ-024 Stop and count-terminate on the same falling transition SHALL give exactly one done_o pulse.
REQ-025 Free-run (count_q=0) SHALL continue until stop; periods_done_o saturation SHALL NOT terminate.
REQ-026 clock_active_o SHALL equal (state==RUN), registered.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, cnt=0, stop_pending=0 and all outputs 0, including periods_done_o, regardless of state.
REQ-028 After rst_n release, the block SHALL respond to start_i on the first clock edge.

Verification
REQ-029 half_rate_i=4, period_count_i=2, start pulse -> io_clk_o low 4 / high 4 / low 4 / high 4 cycles, quarter pulses at cnt 1, done_o one cycle after the 2nd falling transition, periods_done_o=2.
REQ-030 half_rate_i=0 and 1 -> behaves as half_q=2: io_clk_o toggles every 2 cycles; quarter at cnt 0, half at cnt 1.
REQ-031 period_count_i=0, half_rate_i=3, stop_i mid high-phase of period 5 -> finishes that period, done_o once, periods_done_o=5, io_clk_o=0.
REQ-032 period_count_i=1 with stop_i asserted during the same high phase -> single done_o, periods_done_o=1.
REQ-033 rst_n low mid-RUN with io_clk_o=1 -> all outputs 0 asynchronously; new start after release runs cleanly from the low phase.
REQ-034 start_i pulsed in RUN with new half_rate_i=10 -> ignored, period unchanged.
